// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle controller: FSM states,
// opcode encodings, ALU operation codes and the next-state function.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_BZ    = 4'b0100;
    localparam logic [3:0] OP_ALU   = 4'b1000;
    localparam logic [3:0] OP_WIN   = 4'b1010;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_NOT  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;

    // memReady only matters in FETCH and MEM; everywhere else it is ignored.
    function automatic state_e next_state(state_e s, logic [3:0] op, logic rdy);
        state_e n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
            S_DECODE: n = (op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (op == OP_LOAD || op == OP_STORE) n = S_MEM;
                else if (op == OP_ALU)               n = S_WB;
                else                                 n = S_FETCH;
            end
            S_MEM: begin
                if (!rdy)               n = S_MEM;
                else if (op == OP_LOAD) n = S_WB;
                else                    n = S_FETCH;
            end
            S_WB:    n = S_FETCH;
            S_HALT:  n = S_HALT;
            default: n = S_FETCH;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational strobe decode from FSM state, opcode, zero flag and memReady.
// Moore outputs except pcWrite in BZ (zero) and the FETCH/MEM completion strobes.
module mc_decoder import mc_pkg::*; #(
    parameter int ALUOP_W = 3
) (
    input  state_e             state_i,
    input  logic [3:0]         opcode_i,
    input  logic [ALUOP_W-1:0] func_i,
    input  logic               zero_i,
    input  logic               memReady_i,
    output logic               irWrite_o,
    output logic               pcWrite_o,
    output logic               addrSrc_o,
    output logic               memRead_o,
    output logic               memWrite_o,
    output logic               memToReg_o,
    output logic               writeReg_o,
    output logic               aluSrc_o,
    output logic               pcSrc_o,
    output logic               branchPcSrc_o,
    output logic [ALUOP_W-1:0] aluOp_o,
    output logic               retire_o,
    output logic               illegalOp_o,
    output logic               halted_o,
    output logic               winLoad_o
);

    always_comb begin
        irWrite_o     = 1'b0;
        pcWrite_o     = 1'b0;
        addrSrc_o     = 1'b0;
        memRead_o     = 1'b0;
        memWrite_o    = 1'b0;
        memToReg_o    = 1'b0;
        writeReg_o    = 1'b0;
        aluSrc_o      = 1'b0;
        pcSrc_o       = 1'b0;
        branchPcSrc_o = 1'b0;
        aluOp_o       = ALUOP_W'(ALU_ADD);
        retire_o      = 1'b0;
        illegalOp_o   = 1'b0;
        halted_o      = 1'b0;
        winLoad_o     = 1'b0;
        case (state_i)
            S_FETCH: begin
                // PC+1 through the ALU lands together with the IR load.
                memRead_o = 1'b1;
                irWrite_o = memReady_i;
                pcWrite_o = memReady_i;
            end
            S_EXEC: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: aluSrc_o = 1'b1;
                    OP_JUMP: begin
                        pcWrite_o = 1'b1;
                        pcSrc_o   = 1'b1;
                        retire_o  = 1'b1;
                    end
                    OP_BZ: begin
                        aluOp_o       = ALUOP_W'(ALU_SUB);
                        branchPcSrc_o = 1'b1;
                        pcWrite_o     = zero_i;
                        retire_o      = 1'b1;
                    end
                    OP_ALU: aluOp_o = func_i;
                    OP_WIN: begin
                        winLoad_o = 1'b1;
                        retire_o  = 1'b1;
                    end
                    default: illegalOp_o = 1'b1;
                endcase
            end
            S_MEM: begin
                addrSrc_o  = 1'b1;
                memRead_o  = (opcode_i == OP_LOAD);
                memWrite_o = (opcode_i == OP_STORE);
                retire_o   = memReady_i && (opcode_i == OP_STORE);
            end
            S_WB: begin
                writeReg_o = 1'b1;
                memToReg_o = (opcode_i == OP_LOAD);
                retire_o   = 1'b1;
            end
            S_HALT:  halted_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control unit: state register, register-window pointer and the
// reset gating that keeps every strobe quiet while rst_i is high.
module mc_controller import mc_pkg::*; #(
    parameter int INSTR_W = 16,
    parameter int ALUOP_W = 3,
    parameter int WIN_W   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INSTR_W-1:0] instruction_i,
    input  logic               zero_i,
    input  logic               memReady_i,
    output logic               irWrite_o,
    output logic               pcWrite_o,
    output logic               addrSrc_o,
    output logic               memRead_o,
    output logic               memWrite_o,
    output logic               memToReg_o,
    output logic               writeReg_o,
    output logic               aluSrc_o,
    output logic               pcSrc_o,
    output logic               branchPcSrc_o,
    output logic [ALUOP_W-1:0] aluOp_o,
    output logic [WIN_W-1:0]   outWindow_o,
    output logic               retire_o,
    output logic               illegalOp_o,
    output logic               halted_o
);

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_q;
    logic [3:0]         opcode;
    logic               unused_instr;
    logic               d_irWrite, d_pcWrite, d_addrSrc, d_memRead, d_memWrite;
    logic               d_memToReg, d_writeReg, d_aluSrc, d_pcSrc, d_branchPcSrc;
    logic               d_retire, d_illegalOp, d_winLoad;
    logic [ALUOP_W-1:0] d_aluOp;

    assign opcode       = instruction_i[INSTR_W-1 -: 4];
    assign unused_instr = ^instruction_i;
    assign state_d      = next_state(state_q, opcode, memReady_i);

    mc_decoder #(.ALUOP_W(ALUOP_W)) u_dec (
        .state_i       (state_q),
        .opcode_i      (opcode),
        .func_i        (instruction_i[ALUOP_W-1:0]),
        .zero_i        (zero_i),
        .memReady_i    (memReady_i),
        .irWrite_o     (d_irWrite),
        .pcWrite_o     (d_pcWrite),
        .addrSrc_o     (d_addrSrc),
        .memRead_o     (d_memRead),
        .memWrite_o    (d_memWrite),
        .memToReg_o    (d_memToReg),
        .writeReg_o    (d_writeReg),
        .aluSrc_o      (d_aluSrc),
        .pcSrc_o       (d_pcSrc),
        .branchPcSrc_o (d_branchPcSrc),
        .aluOp_o       (d_aluOp),
        .retire_o      (d_retire),
        .illegalOp_o   (d_illegalOp),
        .halted_o      (halted_o),
        .winLoad_o     (d_winLoad)
    );

    // Reset aborts whatever is in flight, so nothing may escape during it.
    assign irWrite_o     = d_irWrite     & ~rst_i;
    assign pcWrite_o     = d_pcWrite     & ~rst_i;
    assign addrSrc_o     = d_addrSrc     & ~rst_i;
    assign memRead_o     = d_memRead     & ~rst_i;
    assign memWrite_o    = d_memWrite    & ~rst_i;
    assign memToReg_o    = d_memToReg    & ~rst_i;
    assign writeReg_o    = d_writeReg    & ~rst_i;
    assign aluSrc_o      = d_aluSrc      & ~rst_i;
    assign pcSrc_o       = d_pcSrc       & ~rst_i;
    assign branchPcSrc_o = d_branchPcSrc & ~rst_i;
    assign retire_o      = d_retire      & ~rst_i;
    assign illegalOp_o   = d_illegalOp   & ~rst_i;
    assign aluOp_o       = rst_i ? '0 : d_aluOp;
    assign outWindow_o   = win_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            if (d_winLoad) win_q <= instruction_i[WIN_W-1:0];
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed table-driven bench for mc_controller with hand-computed strobes
// per cycle, plus hand-written HALT hold and reset-from-HALT sequences.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst, zero, memReady;
    logic [15:0] instr;
    logic        irWrite, pcWrite, addrSrc, memRead, memWrite, memToReg, writeReg;
    logic        aluSrc, pcSrc, branchPcSrc, retire, illegalOp, halted;
    logic [2:0]  aluOp;
    logic [1:0]  outWindow;

    always #5 clk = ~clk;

    mc_controller #(.INSTR_W(16), .ALUOP_W(3), .WIN_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .instruction_i(instr), .zero_i(zero),
        .memReady_i(memReady), .irWrite_o(irWrite), .pcWrite_o(pcWrite),
        .addrSrc_o(addrSrc), .memRead_o(memRead), .memWrite_o(memWrite),
        .memToReg_o(memToReg), .writeReg_o(writeReg), .aluSrc_o(aluSrc),
        .pcSrc_o(pcSrc), .branchPcSrc_o(branchPcSrc), .aluOp_o(aluOp),
        .outWindow_o(outWindow), .retire_o(retire), .illegalOp_o(illegalOp),
        .halted_o(halted)
    );

    localparam logic [12:0] IRW = 13'h1000, PCW = 13'h0800, ADS = 13'h0400,
                            MRD = 13'h0200, MWR = 13'h0100, M2R = 13'h0080,
                            WRG = 13'h0040, ALS = 13'h0020, PCS = 13'h0010,
                            BPS = 13'h0008, RET = 13'h0004, ILL = 13'h0002,
                            HLT = 13'h0001, NON = 13'h0000;

    localparam logic [15:0] I_LD = 16'h0123, I_ST = 16'h1000, I_JMP = 16'h2000,
                            I_BZ = 16'h4000, I_ALU = 16'h8002, I_WIN = 16'hA003,
                            I_BAD = 16'h6000, I_HLT = 16'hF000;

    typedef struct {
        string       name;
        logic        r;
        logic [15:0] ins;
        logic        z;
        logic        rdy;
        logic [12:0] s;
        logic [2:0]  op;
        logic [1:0]  w;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    logic [12:0] strb;
    assign strb = {irWrite, pcWrite, addrSrc, memRead, memWrite, memToReg, writeReg,
                   aluSrc, pcSrc, branchPcSrc, retire, illegalOp, halted};

    function automatic void add(string n, logic r, logic [15:0] i, logic z, logic rdy,
                                logic [12:0] s, logic [2:0] op, logic [1:0] w);
        vec_t v;
        v.name = n; v.r = r; v.ins = i; v.z = z; v.rdy = rdy; v.s = s; v.op = op; v.w = w;
        tbl.push_back(v);
    endfunction

    // Fetch completing immediately, then the one-cycle decode.
    function automatic void fd(string n, logic [15:0] i, logic [1:0] w);
        add({n, "_fetch"},  1'b0, i, 1'b0, 1'b1, MRD | IRW | PCW, 3'd0, w);
        add({n, "_decode"}, 1'b0, i, 1'b0, 1'b1, NON,             3'd0, w);
    endfunction

    task automatic drive(logic r, logic [15:0] i, logic z, logic rdy);
        @(negedge clk);
        rst = r; instr = i; zero = z; memReady = rdy;
        #1;
    endtask

    task automatic check(string n, logic [12:0] s, logic [2:0] op, logic [1:0] w);
        checks++;
        if (strb !== s || aluOp !== op || outWindow !== w) begin
            errors++;
            $display("FAIL %s: got strb=%b aluOp=%0d win=%0d, expected strb=%b aluOp=%0d win=%0d",
                     n, strb, aluOp, outWindow, s, op, w);
        end
    endtask

    initial begin
        rst = 1'b1; instr = '0; zero = 1'b0; memReady = 1'b0;
        repeat (2) @(posedge clk);

        // Reset cycle with memReady high: FETCH completion must stay masked.
        add("rst", 1'b1, I_LD, 1'b0, 1'b1, NON, 3'd0, 2'd0);
        // LOAD, no stalls: 5 cycles.
        fd("ld", I_LD, 2'd0);
        add("ld_exec", 1'b0, I_LD, 1'b0, 1'b1, ALS,             3'd0, 2'd0);
        add("ld_mem",  1'b0, I_LD, 1'b0, 1'b1, MRD | ADS,       3'd0, 2'd0);
        add("ld_wb",   1'b0, I_LD, 1'b0, 1'b1, WRG | M2R | RET, 3'd0, 2'd0);
        // WIN to 3, visible only from the next FETCH; then same value again.
        fd("win", I_WIN, 2'd0);
        add("win_exec",  1'b0, I_WIN, 1'b0, 1'b1, RET, 3'd0, 2'd0);
        fd("win2", I_WIN, 2'd3);
        add("win2_exec", 1'b0, I_WIN, 1'b0, 1'b1, RET, 3'd0, 2'd3);
        // ALU func 2 with a 3-cycle fetch stall.
        add("alu_stall0", 1'b0, I_ALU, 1'b0, 1'b0, MRD, 3'd0, 2'd3);
        add("alu_stall1", 1'b0, I_ALU, 1'b0, 1'b0, MRD, 3'd0, 2'd3);
        add("alu_stall2", 1'b0, I_ALU, 1'b0, 1'b0, MRD, 3'd0, 2'd3);
        fd("alu", I_ALU, 2'd3);
        add("alu_exec", 1'b0, I_ALU, 1'b0, 1'b1, NON,       3'd2, 2'd3);
        add("alu_wb",   1'b0, I_ALU, 1'b0, 1'b1, WRG | RET, 3'd0, 2'd3);
        // BZ taken, then not taken.
        fd("bz1", I_BZ, 2'd3);
        add("bz1_exec", 1'b0, I_BZ, 1'b1, 1'b1, PCW | BPS | RET, 3'd1, 2'd3);
        fd("bz0", I_BZ, 2'd3);
        add("bz0_exec", 1'b0, I_BZ, 1'b0, 1'b1, BPS | RET,       3'd1, 2'd3);
        // Undefined opcode acts as a NOP, then JUMP.
        fd("bad", I_BAD, 2'd3);
        add("bad_exec", 1'b0, I_BAD, 1'b0, 1'b1, ILL, 3'd0, 2'd3);
        fd("jmp", I_JMP, 2'd3);
        add("jmp_exec", 1'b0, I_JMP, 1'b1, 1'b1, PCW | PCS | RET, 3'd0, 2'd3);
        // STORE with two MEM stall cycles.
        fd("st", I_ST, 2'd3);
        add("st_exec",  1'b0, I_ST, 1'b0, 1'b1, ALS,             3'd0, 2'd3);
        add("st_mem0",  1'b0, I_ST, 1'b0, 1'b0, MWR | ADS,       3'd0, 2'd3);
        add("st_mem1",  1'b0, I_ST, 1'b0, 1'b0, MWR | ADS,       3'd0, 2'd3);
        add("st_mem2",  1'b0, I_ST, 1'b0, 1'b1, MWR | ADS | RET, 3'd0, 2'd3);
        // STORE aborted by reset mid-stall.
        fd("sta", I_ST, 2'd3);
        add("sta_exec", 1'b0, I_ST, 1'b0, 1'b1, ALS,       3'd0, 2'd3);
        add("sta_mem",  1'b0, I_ST, 1'b0, 1'b0, MWR | ADS, 3'd0, 2'd3);
        add("sta_rst",  1'b1, I_ST, 1'b0, 1'b0, NON,       3'd0, 2'd3);
        add("sta_post", 1'b0, I_ST, 1'b0, 1'b0, MRD,       3'd0, 2'd0);
        // HALT opcode.
        fd("hlt", I_HLT, 2'd0);

        foreach (tbl[k]) begin
            drive(tbl[k].r, tbl[k].ins, tbl[k].z, tbl[k].rdy);
            check(tbl[k].name, tbl[k].s, tbl[k].op, tbl[k].w);
        end

        // HALT holds for 20 cycles regardless of memReady/zero.
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, (c % 2 == 0) ? I_LD : I_HLT, 1'b1, 1'b1);
            check($sformatf("halt_hold%0d", c), HLT, 3'd0, 2'd0);
        end
        // Reset from HALT: strobes masked, halted still reflects state this cycle.
        drive(1'b1, I_LD, 1'b1, 1'b1);
        check("halt_rst", HLT, 3'd0, 2'd0);
        drive(1'b0, I_LD, 1'b0, 1'b1);
        check("halt_exit_fetch", MRD | IRW | PCW, 3'd0, 2'd0);
        drive(1'b0, I_LD, 1'b0, 1'b1);
        check("halt_exit_decode", NON, 3'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
